// File: rtl/hazard_ctl_pkg.sv
// Shared types and constants for the hazard controller: FSM encoding, opcodes, scoreboard entry.
// Pure declarations; no timing or backpressure of its own.
package hazard_ctl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctlState_t;

    localparam logic [4:0] OPC_HALT     = 5'b0_0000;
    localparam logic [4:0] OPC_NOP      = 5'b0_0001;
    localparam int         DRAIN_CYCLES = 3;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } sbEntry_t;

    function automatic logic sbHit(input sbEntry_t e, input logic [2:0] r);
        return e.valid && (e.idx == r);
    endfunction

endpackage

// File: rtl/hazard_ctl_if.sv
// ID-stage hazard handshake: decode-side inputs and the stall/flush/valid controls back to the pipe.
// Combinational bundle; no latency, no backpressure.
interface hazard_ctl_if;
    logic [4:0] opcode;
    logic       ifidValid;
    logic [2:0] rsIdx;
    logic [2:0] rtIdx;
    logic       rsUsed;
    logic       rtUsed;
    logic [2:0] wrIdx;
    logic       wrEn;
    logic       exTaken;
    logic       validIns;
    logic       stallF;
    logic       flushD;
    logic       halted;

    modport master (
        output opcode, ifidValid, rsIdx, rtIdx, rsUsed, rtUsed, wrIdx, wrEn, exTaken,
        input  validIns, stallF, flushD, halted
    );

    modport slave (
        input  opcode, ifidValid, rsIdx, rtIdx, rsUsed, rtUsed, wrIdx, wrEn, exTaken,
        output validIns, stallF, flushD, halted
    );
endinterface

// File: rtl/hazard_sb.sv
// Two-entry destination scoreboard (EX, MEM) with RAW compare against the ID sources.
// Shifts every cycle; raw is combinational from registered entries and current ID indices.
module hazard_sb
    import hazard_ctl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [2:0] wrIdx,
    input  logic       ifidValid,
    input  logic [2:0] rsIdx,
    input  logic [2:0] rtIdx,
    input  logic       rsUsed,
    input  logic       rtUsed,
    output logic       raw
);

    sbEntry_t sb1;
    sbEntry_t sb2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sb1 <= '0;
            sb2 <= '0;
        end else begin
            sb2 <= sb1;
            sb1 <= push ? sbEntry_t'{valid: 1'b1, idx: wrIdx} : '0;
        end
    end

    // WB writes are covered by the register-file bypass, so only EX and MEM are compared.
    always_comb begin
        raw = ifidValid &&
              ((rsUsed && (sbHit(sb1, rsIdx) || sbHit(sb2, rsIdx))) ||
               (rtUsed && (sbHit(sb1, rtIdx) || sbHit(sb2, rtIdx))));
    end

endmodule

// File: rtl/hazard_ctl.sv
// In-order pipeline hazard control: RAW stalls, EX redirect flush, halt drain to a parked state.
// Outputs are combinational from state/scoreboard/inputs; state updates on the next rising edge.
module hazard_ctl (
    input  logic         clk,
    input  logic         rst,
    hazard_ctl_if.slave  hz
);
    import hazard_ctl_pkg::*;

    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    ctlState_t  state;
    logic [1:0] drainCnt;
    logic       raw;
    logic       validIns;
    logic       stallF;
    logic       flushD;
    logic       halted;
    logic       haltIssue;

    hazard_sb uSb (
        .clk       (clk),
        .rst       (rst),
        .push      (validIns & hz.wrEn),
        .wrIdx     (hz.wrIdx),
        .ifidValid (hz.ifidValid),
        .rsIdx     (hz.rsIdx),
        .rtIdx     (hz.rtIdx),
        .rsUsed    (hz.rsUsed),
        .rtUsed    (hz.rtUsed),
        .raw       (raw)
    );

    // A redirect outranks a RAW stall: the stalled instruction is on the wrong path anyway.
    always_comb begin
        validIns = 1'b0;
        stallF   = 1'b0;
        flushD   = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            flushD = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hz.exTaken) begin
                        flushD = 1'b1;
                    end else if (raw) begin
                        stallF = 1'b1;
                    end else begin
                        validIns = hz.ifidValid;
                    end
                end
                DRAIN: begin
                    stallF = 1'b1;
                end
                HALTED: begin
                    stallF = 1'b1;
                    halted = 1'b1;
                end
                default: begin
                    stallF = 1'b1;
                end
            endcase
        end
    end

    assign haltIssue = validIns && (hz.opcode == OPC_HALT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            drainCnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (haltIssue) begin
                        state    <= DRAIN;
                        drainCnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drainCnt == DRAIN_LAST) begin
                        state <= HALTED;
                    end else begin
                        drainCnt <= drainCnt + 2'd1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign hz.validIns = validIns;
    assign hz.stallF   = stallF;
    assign hz.flushD   = flushD;
    assign hz.halted   = halted;

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed and randomized checks of hazard_ctl against a cycle-indexed issue-log model.
module tb_hazard_ctl;
    import hazard_ctl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hazard_ctl_if hif ();

    hazard_ctl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    always #5 clk = ~clk;

    // Model: every issued register write is logged with its issue cycle.
    typedef struct {
        int         cyc;
        logic [2:0] idx;
    } wrRec_t;

    wrRec_t wq[$];
    int     now      = 0;
    int     haltAt   = -1;
    int     checks   = 0;
    int     failures = 0;

    // A write is still unforwardable while issued one or two cycles ago.
    function automatic logic pending(input logic [2:0] r);
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].cyc >= now - 2 && wq[i].idx == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, now, got, exp);
        end
    endtask

    task automatic setIns(input logic [4:0] opc, input logic ifv,
                          input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu,
                          input logic [2:0] wi, input logic we, input logic ex);
        hif.opcode    = opc;
        hif.ifidValid = ifv;
        hif.rsIdx     = rs;
        hif.rsUsed    = rsu;
        hif.rtIdx     = rt;
        hif.rtUsed    = rtu;
        hif.wrIdx     = wi;
        hif.wrEn      = we;
        hif.exTaken   = ex;
    endtask

    task automatic step(input int dirStall = -1);
        logic   eV, eS, eF, eH, rawHit;
        int     age;
        wrRec_t rec;
        @(negedge clk);
        age    = (haltAt >= 0) ? (now - haltAt) : -1;
        rawHit = hif.ifidValid && ((hif.rsUsed && pending(hif.rsIdx)) ||
                                   (hif.rtUsed && pending(hif.rtIdx)));
        eV = 1'b0; eS = 1'b0; eF = 1'b0; eH = 1'b0;
        if (!rst) begin
            eF = 1'b1;
        end else if (age >= DRAIN_CYCLES + 1) begin
            eS = 1'b1;
            eH = 1'b1;
        end else if (age >= 1) begin
            eS = 1'b1;
        end else if (hif.exTaken) begin
            eF = 1'b1;
        end else if (rawHit) begin
            eS = 1'b1;
        end else begin
            eV = hif.ifidValid;
        end
        chk("validIns", hif.validIns, eV);
        chk("stallF",   hif.stallF,   eS);
        chk("flushD",   hif.flushD,   eF);
        chk("halted",   hif.halted,   eH);
        if (dirStall >= 0) chk("dirStall", hif.stallF, dirStall[0]);
        @(posedge clk);
        if (!rst) begin
            wq.delete();
            haltAt = -1;
        end else begin
            if (eV && hif.wrEn) begin
                rec.cyc = now;
                rec.idx = hif.wrIdx;
                wq.push_back(rec);
            end
            if (eV && hif.opcode == OPC_HALT) haltAt = now;
        end
        now++;
        while (wq.size() > 0 && wq[0].cyc < now - 2) void'(wq.pop_front());
        #1;
    endtask

    initial begin
        setIns(OPC_NOP, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(0);
        step(0);
        rst = 1'b1;

        // Distance-1 RAW on rs: two stall cycles then issue.
        setIns(5'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0); step(0);
        setIns(5'd4, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); step(1);
        step(1);
        step(0);

        // Distance-2 RAW on rt: one stall cycle.
        setIns(5'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0); step(0);
        setIns(5'd6, 1'b1, 3'd1, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0); step(0);
        setIns(5'd4, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0); step(1);
        step(0);

        // Matching but unused rs does not stall.
        setIns(5'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0); step(0);
        setIns(5'd4, 1'b1, 3'd2, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0); step(0);

        // Redirect overrides the stall; producer still in MEM afterwards.
        setIns(5'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0); step(0);
        setIns(5'd4, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1); step(0);
        setIns(5'd4, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); step(1);
        step(0);

        // Squashed halt, stalled halt, then issued halt with a redirect during drain.
        setIns(OPC_HALT, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1); step(0);
        setIns(5'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0); step(0);
        setIns(OPC_HALT, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); step(1);
        step(1);
        step(0);
        setIns(5'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); step(1);
        setIns(5'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1); step(1);
        setIns(5'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); step(1);
        step(1);
        chk("haltedAtT4", hif.halted, 1'b1);
        step(1);

        // Reset mid-drain returns to RUN with an empty scoreboard.
        rst = 1'b0; step(0);
        rst = 1'b1;
        setIns(5'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0); step(0);
        setIns(OPC_HALT, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); step(0);
        setIns(5'd4, 1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); step(1);
        rst = 1'b0; step(0);
        rst = 1'b1;
        setIns(5'd4, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 1'b0); step(0);
        step(1);

        // Randomized traffic; reset periodically to leave HALTED.
        for (int n = 0; n < 600; n++) begin
            rst = !(haltAt >= 0 && now - haltAt >= 6) && ($urandom_range(0, 99) != 0);
            setIns(($urandom_range(0, 24) == 0) ? OPC_HALT : 5'($urandom_range(1, 31)),
                   $urandom_range(0, 5) != 0,
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                   $urandom_range(0, 7) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
